// File: rtl/dca_matrix_store_row_packer.sv
// dca_matrix_store_row_packer: serializes tensor rows into AXI W-channel beats with strobes and wlast.
// Define DCA_STORE_PACKER_ZERO_FILL_EN to force unstrobed wdata bytes to zero.
module dca_matrix_store_row_packer #(
   parameter int ELEMENT_WIDTH  = 32,
   parameter int ROW_ELEMENTS   = 4,
   parameter int AXI_DATA_WIDTH = 32,
   localparam int ROW_W = ELEMENT_WIDTH * ROW_ELEMENTS,
   localparam int CW    = $clog2(ROW_ELEMENTS),
   localparam int SW    = AXI_DATA_WIDTH / 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      cmd_valid,
   output logic                      cmd_ready,
   input  logic [7:0]                cmd_num_rows,
   input  logic [CW-1:0]             cmd_num_cols,
   input  logic                      row_valid,
   output logic                      row_ready,
   input  logic [ROW_W-1:0]          row_data,
   output logic                      wvalid,
   input  logic                      wready,
   output logic [AXI_DATA_WIDTH-1:0] wdata,
   output logic [SW-1:0]             wstrb,
   output logic                      wlast,
   output logic                      busy,
   output logic                      done
);
   localparam int BPR = ROW_W / AXI_DATA_WIDTH;
   localparam int EPB = AXI_DATA_WIDTH / ELEMENT_WIDTH;
   localparam int BW  = BPR > 1 ? $clog2(BPR) : 1;
   localparam int EB  = ELEMENT_WIDTH / 8;
   localparam logic [BW-1:0] LAST_BEAT = BW'(BPR - 1);

   typedef enum logic [1:0] {IDLE, LOAD, SEND} state_t;

   state_t                    state_q, state_d;
   logic [7:0]                rows_q, rows_d, row_cnt_q, row_cnt_d;
   logic [CW-1:0]             cols_q, cols_d;
   logic [BW-1:0]             beat_q, beat_d;
   logic [ROW_W-1:0]          row_reg_q, row_reg_d;
   logic                      done_q, done_d;
   logic                      last_beat, last_row;
   logic [AXI_DATA_WIDTH-1:0] raw;

   assign cmd_ready = state_q == IDLE;
   assign busy      = !cmd_ready;
   assign wvalid    = state_q == SEND;
   assign last_beat = beat_q == LAST_BEAT;
   assign last_row  = row_cnt_q == rows_q;
   assign wlast     = wvalid && last_beat && last_row;
   assign done      = done_q;
   // Early row_ready on the row's final beat lets the next row land with no bubble
   assign row_ready = state_q == LOAD || (wvalid && wready && last_beat && !last_row);
   assign raw       = row_reg_q[int'(beat_q)*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];

   always_comb begin
      wstrb = '0;
      for (int j = 0; j < SW; j++)
         wstrb[j] = wvalid && (int'(beat_q)*EPB + j/EB <= int'(cols_q));
   end

`ifdef DCA_STORE_PACKER_ZERO_FILL_EN
   always_comb begin
      wdata = '0;
      for (int j = 0; j < SW; j++)
         wdata[j*8 +: 8] = wstrb[j] ? raw[j*8 +: 8] : 8'h00;
   end
`else
   assign wdata = raw;
`endif

   always_comb begin
      state_d   = state_q;
      rows_d    = rows_q;
      cols_d    = cols_q;
      row_cnt_d = row_cnt_q;
      beat_d    = beat_q;
      row_reg_d = row_reg_q;
      done_d    = 1'b0;
      case (state_q)
         IDLE: if (cmd_valid) begin
            rows_d    = cmd_num_rows;
            cols_d    = cmd_num_cols;
            row_cnt_d = '0;
            state_d   = LOAD;
         end
         LOAD: if (row_valid) begin
            row_reg_d = row_data;
            beat_d    = '0;
            state_d   = SEND;
         end
         SEND: if (wready) begin
            if (!last_beat) beat_d = beat_q + 1'b1;
            else if (!last_row) begin
               row_cnt_d = row_cnt_q + 8'd1;
               if (row_valid) begin
                  row_reg_d = row_data;
                  beat_d    = '0;
               end else state_d = LOAD;
            end else begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         rows_q    <= '0;
         cols_q    <= '0;
         row_cnt_q <= '0;
         beat_q    <= '0;
         row_reg_q <= '0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         rows_q    <= rows_d;
         cols_q    <= cols_d;
         row_cnt_q <= row_cnt_d;
         beat_q    <= beat_d;
         row_reg_q <= row_reg_d;
         done_q    <= done_d;
      end
   end
endmodule

// File: tb/tb_dca_matrix_store_row_packer.sv
// tb_dca_matrix_store_row_packer: directed bench for the store row packer (32b elements, 4 per row, 32b beats).
module tb_dca_matrix_store_row_packer;
   logic         clk = 1'b0;
   logic         rst;
   logic         cmd_valid, cmd_ready, row_valid, row_ready;
   logic [7:0]   cmd_num_rows;
   logic [1:0]   cmd_num_cols;
   logic [127:0] row_data;
   logic         wvalid, wready, wlast, busy, done;
   logic [31:0]  wdata;
   logic [3:0]   wstrb;
   logic [127:0] rows_mem [4];
   int           n_chk = 0;
   int           n_err = 0;

   always #5 clk = ~clk;

   dca_matrix_store_row_packer dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_num_rows(cmd_num_rows), .cmd_num_cols(cmd_num_cols),
      .row_valid(row_valid), .row_ready(row_ready), .row_data(row_data),
      .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
      .wlast(wlast), .busy(busy), .done(done)
   );

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_cmd_ready"}, cmd_ready, 1);
      check({tag, "_row_ready"}, row_ready, 0);
      check({tag, "_wvalid"}, wvalid, 0);
      check({tag, "_wlast"}, wlast, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_wdata"}, wdata, 0);
      check({tag, "_wstrb"}, wstrb, 0);
   endtask

   // Runs one transaction; toggle alternates wready, poke pulses cmd_valid mid-run,
   // abort_at > 0 returns just before the edge that accepts that many beats.
   task automatic run(input logic [7:0] nr, input logic [1:0] nc, input bit toggle,
                      input bit poke, input int abort_at);
      int bi = 0, ri = 0, cyc = 0, vcyc = 0, rr = 0;
      int total = (int'(nr) + 1) * 4;
      bit stall = 0, got_done = 0;
      logic [31:0] pd, exp_d;
      logic [3:0]  ps, exp_s;
      logic        pl;
      cmd_valid = 1'b1;
      cmd_num_rows = nr;
      cmd_num_cols = nc;
      #1;
      check("cmd_ready_idle", cmd_ready, 1);
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      check("busy_after_cmd", busy, 1);
      while (!got_done && cyc < 200) begin
         wready = toggle ? (cyc % 2 == 0) : 1'b1;
         row_valid = ri <= int'(nr);
         row_data = ri < 4 ? rows_mem[ri] : '0;
         cmd_valid = poke && cyc == 3;
         if (poke && cyc == 3) cmd_num_rows = 8'd9;
         #1;
         if (cyc == 0) check("row_ready_after_cmd", row_ready, 1);
         if (poke && cyc == 3) check("cmd_ignored_busy", cmd_ready, 0);
         if (stall) begin
            check("stable_wdata", wdata, pd);
            check("stable_wstrb", wstrb, ps);
            check("stable_wlast", wlast, pl);
         end
         stall = wvalid && !wready;
         pd = wdata;
         ps = wstrb;
         pl = wlast;
         if (row_ready) rr++;
         if (row_ready && row_valid) ri++;
         if (wvalid) vcyc++;
         if (wvalid && wready) begin
            exp_s = (bi % 4) <= int'(nc) ? 4'hF : 4'h0;
            exp_d = rows_mem[bi / 4][(bi % 4) * 32 +: 32];
`ifdef DCA_STORE_PACKER_ZERO_FILL_EN
            if (exp_s == 4'h0) exp_d = '0;
`endif
            check($sformatf("wdata_b%0d", bi), wdata, exp_d);
            check($sformatf("wstrb_b%0d", bi), wstrb, exp_s);
            check($sformatf("wlast_b%0d", bi), wlast, bi == total - 1);
            bi++;
         end
         if (done) begin
            got_done = 1;
            check("done_cmd_ready", cmd_ready, 1);
            check("done_wvalid", wvalid, 0);
            check("done_after_last", bi, total);
            if (!toggle) check("latency", cyc, total + 1);
         end
         if (abort_at > 0 && bi == abort_at) return;
         @(posedge clk);
         #1;
         cyc++;
      end
      cmd_valid = 1'b0;
      check("done_seen", got_done, 1);
      check("beat_count", bi, total);
      check("row_ready_cycles", rr, int'(nr) + 1);
      if (!toggle) check("wvalid_cycles", vcyc, total);
      @(posedge clk);
      #1;
      check("done_one_cycle", done, 0);
      check("idle_after", busy, 0);
   endtask

   initial begin
      rst = 1'b1;
      cmd_valid = 1'b0;
      cmd_num_rows = '0;
      cmd_num_cols = '0;
      row_valid = 1'b0;
      row_data = '0;
      wready = 1'b0;
      #1;
      check_reset_outputs("reset");
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
      check_reset_outputs("post_reset");

      rows_mem[0] = 128'hA3A3A3A3_A2A2A2A2_A1A1A1A1_44332211;
      rows_mem[1] = 128'hB3B3B3B3_B2B2B2B2_B1B1B1B1_B0B0B0B0;
      run(8'd1, 2'd3, 0, 0, 0);

      rows_mem[0] = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
      run(8'd0, 2'd1, 0, 0, 0);

      rows_mem[0] = 128'h13121110_0F0E0D0C_0B0A0908_07060504;
      rows_mem[1] = 128'h23222120_1F1E1D1C_1B1A1918_17161514;
      run(8'd1, 2'd3, 1, 0, 0);

      rows_mem[2] = 128'h33333333_32323232_31313131_30303030;
      rows_mem[3] = 128'h43434343_42424242_41414141_40404040;
      run(8'd3, 2'd2, 0, 0, 0);

      run(8'd0, 2'd3, 0, 0, 3);
      @(posedge clk);
      #1;
      rst = 1'b1;
      row_valid = 1'b0;
      wready = 1'b0;
      #1;
      check_reset_outputs("abort");
      @(posedge clk);
      #1;
      check("abort_hold_wvalid", wvalid, 0);
      rst = 1'b0;
      @(posedge clk);
      #1;
      rows_mem[0] = 128'h5A5A5A5A_69696969_78787878_87878787;
      run(8'd0, 2'd3, 0, 0, 0);

      rows_mem[0] = 128'hFEDCBA98_76543210_0F1E2D3C_4B5A6978;
      rows_mem[1] = 128'h11112222_33334444_55556666_77778888;
      run(8'd1, 2'd3, 0, 1, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
